// File: rtl/axis_rom_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_rom_sequencer_if                                                      |
// | Command, ROM-read and AXI-Stream signals of the ROM sequencer.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface axis_rom_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 61200,
  parameter int LEN_W = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             rom_en;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic [WIDTH-1:0] axis_d;
  logic             axis_valid;
  logic             axis_ready;
  logic             axis_last;
  logic             busy;
  logic             err;

  // master: the sequencer itself; slave: the command source, ROM and stream sink
  modport master (
    input  cmd_addr, cmd_len, cmd_valid, rom_data, axis_ready,
    output cmd_ready, rom_en, rom_addr, axis_d, axis_valid, axis_last, busy, err
  );

  modport slave (
    output cmd_addr, cmd_len, cmd_valid, rom_data, axis_ready,
    input  cmd_ready, rom_en, rom_addr, axis_d, axis_valid, axis_last, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/axis_rom_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_rom_sequencer                                                         |
// | Streams a ROM segment (start address, length) out as AXI-Stream beats.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axis_rom_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 61200,
  parameter int LEN_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  axis_rom_sequencer_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             err_q, err_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic [1:0]       last_q, last_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;

  logic             cmd_ready_int;
  logic             issue;
  logic             axis_valid_int;
  logic             pop;
  logic             push;
  logic [2:0]       load;
  logic             credit_ok;

  assign axis_valid_int = (count_q != 2'd0) && !rst;
  assign pop            = axis_valid_int && bus.axis_ready;
  assign push           = inflight_q;
  // A read may issue if, after this cycle's pop, buffered plus in-flight words leave room
  assign load           = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit_ok      = (count_q != 2'd2) && (load < 3'd2);

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    err_d           = 1'b0;
    cmd_ready_int   = 1'b0;
    issue           = 1'b0;
    inflight_last_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_int = 1'b1;
        if (bus.cmd_valid) begin
          if (({1'b0, bus.cmd_addr} >= DEPTH_X) || (bus.cmd_len == '0)) begin
            err_d = 1'b1;
          end else begin
            cur_addr_d  = bus.cmd_addr;
            remaining_d = bus.cmd_len;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if ((remaining_q != '0) && credit_ok) begin
          issue       = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
          cur_addr_d  = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + AW'(1);
          if (remaining_q == LEN_W'(1)) begin
            inflight_last_d = 1'b1;
            state_d         = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && last_q[rd_ptr_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    inflight_d = issue;
  end

  always_comb begin
    mem_d    = mem_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q]  = bus.rom_data;
      last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      err_q           <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      mem_q[0]        <= '0;
      mem_q[1]        <= '0;
      last_q          <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      err_q           <= err_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      mem_q[0]        <= mem_d[0];
      mem_q[1]        <= mem_d[1];
      last_q          <= last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

  // Outputs are forced quiet while rst is held, before the flops have been cleared
  assign bus.cmd_ready  = cmd_ready_int && !rst;
  assign bus.rom_en     = issue && !rst;
  assign bus.rom_addr   = cur_addr_q;
  assign bus.axis_valid = axis_valid_int;
  assign bus.axis_d     = mem_q[rd_ptr_q];
  assign bus.axis_last  = axis_valid_int && last_q[rd_ptr_q];
  assign bus.busy       = !rst && ((state_q != S_IDLE) || (count_q != 2'd0));
  assign bus.err        = err_q && !rst;
endmodule
`default_nettype wire
